// File: rtl/led_strobe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_strobe_pkg
// Description : Shared types and default sizing for the LED strobe generator:
//               sequencer state encoding, default channel/field widths and
//               the last counter value of a frame.
// Revision    : 1.0 - initial release
// ============================================================================
package led_strobe_pkg;

  localparam int NCH_DEF   = 5;
  localparam int FBITS_DEF = 12;
  localparam int WBITS_DEF = 8;

  // Last frame counter value for a frame of 2^fbits clocks
  function automatic int frame_last(input int fbits);
    return (1 << fbits) - 1;
  endfunction

  localparam int FRAME_LAST = (1 << FBITS_DEF) - 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/strobe_channel.sv
`default_nettype none
// ============================================================================
// Module      : strobe_channel
// Description : One emitter channel. Holds the pending (software-written) and
//               active (frame-locked) phase/width pair and decodes whether the
//               frame counter lies inside the active strobe window.
// Revision    : 1.0 - initial release
// ============================================================================
module strobe_channel
  import led_strobe_pkg::*;
#(
  parameter int FBITS = FBITS_DEF,
  parameter int WBITS = WBITS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr,
  input  logic [FBITS-1:0] i_phase,
  input  logic [WBITS-1:0] i_width,
  input  logic             i_load,
  input  logic [FBITS-1:0] i_cnt,
  output logic             o_hit
);

  logic [FBITS-1:0] r_pend_phase;
  logic [WBITS-1:0] r_pend_width;
  logic [FBITS-1:0] r_act_phase;
  logic [WBITS-1:0] r_act_width;
  logic [FBITS:0]   w_end;

  // Pending pair captures accepted configuration writes for this channel
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_phase <= '0;
      r_pend_width <= '0;
    end else if (i_wr) begin
      r_pend_phase <= i_phase;
      r_pend_width <= i_width;
    end
  end

  // Active pair only changes at run start or frame wrap, so a frame is never torn
  always_ff @(posedge clk) begin
    if (rst) begin
      r_act_phase <= '0;
      r_act_width <= '0;
    end else if (i_load) begin
      r_act_phase <= r_pend_phase;
      r_act_width <= r_pend_width;
    end
  end

  // Window end is one bit wider so a window running past the frame end is
  // simply clipped instead of wrapping into the start of the next frame.
  assign w_end = {1'b0, r_act_phase} + (FBITS+1)'(r_act_width);
  assign o_hit = (i_cnt >= r_act_phase) && ({1'b0, i_cnt} < w_end);

endmodule
`default_nettype wire

// File: rtl/led_strobe_gen.sv
`default_nettype none
// ============================================================================
// Module      : led_strobe_gen
// Description : Frame-based multi-channel LED strobe generator. A free-running
//               frame counter drives NCH phase/width windows; a small
//               IDLE/RUN/DRAIN sequencer lets runs finish on frame boundaries.
//               Optional feature macro: LED_STROBE_BURST_EN adds a burst_len
//               port that ends a run after a fixed number of frames.
// Revision    : 1.0 - initial release
// ============================================================================
module led_strobe_gen
  import led_strobe_pkg::*;
#(
  parameter int NCH   = NCH_DEF,
  parameter int FBITS = FBITS_DEF,
  parameter int WBITS = WBITS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [2:0]       cfg_ch,
  input  logic [FBITS-1:0] cfg_phase,
  input  logic [WBITS-1:0] cfg_width,
  input  logic             start,
  input  logic             stop,
`ifdef LED_STROBE_BURST_EN
  input  logic [15:0]      burst_len,
`endif
  output logic [NCH-1:0]   strobe,
  output logic             frame_sync,
  output logic             busy,
  output logic             done
);

  localparam logic [FBITS-1:0] c_FRAME_LAST = FBITS'(frame_last(FBITS));

  state_t           r_state;
  state_t           w_state_nxt;
  logic [FBITS-1:0] r_cnt;
  logic [NCH-1:0]   r_strobe;
  logic             r_frame_sync;
  logic             r_done;
  logic [NCH-1:0]   w_hit;
  logic             w_active;
  logic             w_at_last;
  logic             w_wrap;
  logic             w_launch;
  logic             w_load;
  logic             w_xfer;
  logic             w_stop_req;

  assign w_active  = (r_state != ST_IDLE);
  assign w_at_last = (r_cnt == c_FRAME_LAST);
  assign w_wrap    = w_active && w_at_last;
  // start together with stop in IDLE is treated as no request
  assign w_launch  = (r_state == ST_IDLE) && start && !stop;
  assign w_load    = w_launch || w_wrap;
  // Writes are refused only on the frame-wrap cycle, when active values reload
  assign cfg_ready = !w_wrap;
  assign w_xfer    = cfg_valid && cfg_ready;

`ifdef LED_STROBE_BURST_EN
  logic [15:0] r_frames;

  // Frame number within the current run, 1 for the first frame
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frames <= '0;
    end else if (w_launch) begin
      r_frames <= 16'd1;
    end else if (w_wrap) begin
      r_frames <= r_frames + 16'd1;
    end
  end

  assign w_stop_req = stop || ((burst_len != 16'd0) && (r_frames == burst_len));
`else
  assign w_stop_req = stop;
`endif

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Sequencer next state; a stop in DRAIN is a no-op
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_launch)   w_state_nxt = ST_RUN;
      ST_RUN:   if (w_stop_req) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_at_last)  w_state_nxt = ST_IDLE;
      default:                  w_state_nxt = ST_IDLE;
    endcase
  end

  // Frame counter: restarts at run launch, free-runs (and wraps) while busy
  always_ff @(posedge clk) begin
    if (rst || w_launch) begin
      r_cnt <= '0;
    end else if (w_active) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  generate
    for (genvar i = 0; i < NCH; i++) begin : g_ch
      strobe_channel #(
        .FBITS (FBITS),
        .WBITS (WBITS)
      ) u_ch (
        .clk     (clk),
        .rst     (rst),
        .i_wr    (w_xfer && (cfg_ch == 3'(i))),
        .i_phase (cfg_phase),
        .i_width (cfg_width),
        .i_load  (w_load),
        .i_cnt   (r_cnt),
        .o_hit   (w_hit[i])
      );
    end
  endgenerate

  // Registered outputs lag the counter by one cycle; strobes are gated in IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_strobe     <= '0;
      r_frame_sync <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_strobe     <= w_active ? w_hit : '0;
      r_frame_sync <= w_active && (r_cnt == '0);
      r_done       <= (r_state == ST_DRAIN) && w_at_last;
    end
  end

  assign strobe     = r_strobe;
  assign frame_sync = r_frame_sync;
  assign done       = r_done;
  assign busy       = w_active;

endmodule
`default_nettype wire

// File: tb/tb_led_strobe_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_strobe_gen
// Description : Self-checking bench for led_strobe_gen. A frame-level model
//               predicts every cycle's outputs into a queue; an independent
//               monitor pops and compares each cycle. Directed pulse tallies
//               cover the frame/strobe counts of the main use cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_strobe_gen;
  import led_strobe_pkg::*;

  localparam int NCH   = 5;
  localparam int FBITS = 12;
  localparam int WBITS = 8;
  localparam int LAST  = FRAME_LAST;
  localparam int FLEN  = LAST + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [2:0]       cfg_ch = '0;
  logic [FBITS-1:0] cfg_phase = '0;
  logic [WBITS-1:0] cfg_width = '0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
`ifdef LED_STROBE_BURST_EN
  logic [15:0]      burst_len = '0;
`endif
  logic [NCH-1:0]   strobe;
  logic             frame_sync;
  logic             busy;
  logic             done;

  always #5 clk = ~clk;

  led_strobe_gen #(.NCH(NCH), .FBITS(FBITS), .WBITS(WBITS)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_phase  (cfg_phase),
    .cfg_width  (cfg_width),
    .start      (start),
    .stop       (stop),
`ifdef LED_STROBE_BURST_EN
    .burst_len  (burst_len),
`endif
    .strobe     (strobe),
    .frame_sync (frame_sync),
    .busy       (busy),
    .done       (done)
  );

  typedef struct packed {
    logic [NCH-1:0] strb;
    logic           fs;
    logic           bsy;
    logic           dn;
    logic           rdy;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Pulse tallies kept by the monitor, read by directed checks
  int n_fs = 0, n_done = 0;
  int n_s[NCH];

  // Reference model: mode 0 idle / 1 running / 2 finishing frame, pos = position in frame
  int m_mode = 0, m_pos = 0, m_frames = 0;
  int pend_ph[8], pend_w[8], act_ph[NCH], act_w[NCH];

  // Predict the outputs seen after the next rising edge from the present inputs
  task automatic model_step();
    obs_t e;
    int   nmode;
    bit   frame_end, launch, stop_now;
    e = '0;
    if (rst) begin
      m_mode = 0; m_pos = 0; m_frames = 0;
      for (int i = 0; i < 8; i++) begin pend_ph[i] = 0; pend_w[i] = 0; end
      for (int i = 0; i < NCH; i++) begin act_ph[i] = 0; act_w[i] = 0; end
      e.rdy = 1'b1;
    end else begin
      for (int i = 0; i < NCH; i++)
        e.strb[i] = (m_mode != 0) && (m_pos >= act_ph[i]) && (m_pos < act_ph[i] + act_w[i]);
      e.fs      = (m_mode != 0) && (m_pos == 0);
      e.dn      = (m_mode == 2) && (m_pos == LAST);
      frame_end = (m_mode != 0) && (m_pos == LAST);
      launch    = (m_mode == 0) && start && !stop;
      if (launch || frame_end)
        for (int i = 0; i < NCH; i++) begin act_ph[i] = pend_ph[i]; act_w[i] = pend_w[i]; end
      if (cfg_valid && !frame_end) begin
        pend_ph[cfg_ch] = int'(cfg_phase);
        pend_w[cfg_ch]  = int'(cfg_width);
      end
      stop_now = stop;
`ifdef LED_STROBE_BURST_EN
      if (burst_len != 0 && m_frames == int'(burst_len)) stop_now = 1'b1;
`endif
      if (launch) m_frames = 1;
      else if (frame_end) m_frames = (m_frames + 1) % 65536;
      case (m_mode)
        0:       nmode = launch ? 1 : 0;
        1:       nmode = stop_now ? 2 : 1;
        default: nmode = (m_pos == LAST) ? 0 : 2;
      endcase
      if (launch) m_pos = 0;
      else if (m_mode != 0) m_pos = (m_pos + 1) % FLEN;
      m_mode = nmode;
      e.bsy = (m_mode != 0);
      e.rdy = !((m_mode != 0) && (m_pos == LAST));
    end
    exp_q.push_back(e);
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic chk(input string name, input int got, input int expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, expv);
    end
  endtask

  // Hold a write until accepted; cfg_ready is only used to pace the driver
  task automatic cfg_write(input int ch, input int ph, input int w);
    bit acc;
    int guard;
    guard = 0;
    cfg_valid = 1'b1;
    cfg_ch    = 3'(ch);
    cfg_phase = FBITS'(ph);
    cfg_width = WBITS'(w);
    do begin
      acc = cfg_ready;
      tick();
      guard++;
    end while (!acc && guard < 8);
    cfg_valid = 1'b0;
    chk("cfg_accepted", int'(acc), 1);
  endtask

  // Monitor: one comparison per cycle while predictions are queued
  initial begin
    obs_t e, a;
    for (int i = 0; i < NCH; i++) n_s[i] = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {strobe, frame_sync, busy, done, cfg_ready};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL cycle_outputs t=%0t got strobe=%b fs=%b busy=%b done=%b ready=%b expected strobe=%b fs=%b busy=%b done=%b ready=%b",
                   $time, a.strb, a.fs, a.bsy, a.dn, a.rdy, e.strb, e.fs, e.bsy, e.dn, e.rdy);
        end
        if (frame_sync) n_fs++;
        if (done) n_done++;
        for (int i = 0; i < NCH; i++) if (strobe[i]) n_s[i]++;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_fs, b_done, b_s0, b_s1, b_s3, b_s4;

    // Reset
    rst = 1'b1;
    run(3);
    rst = 1'b0;
    run(2);

    // Scenario A: two full frames, stop at counter 10 of the third, drain
    cfg_write(0, 100, 20);
    cfg_write(1, 4090, 20);
    cfg_write(2, 50, 0);
    cfg_write(7, 5, 50);
    cfg_write(3, 4000, 255);
    cfg_write(4, 0, 1);
    #1;
    b_fs = n_fs; b_done = n_done; b_s0 = n_s[0]; b_s1 = n_s[1]; b_s3 = n_s[3]; b_s4 = n_s[4];
    start = 1'b1; tick(); start = 1'b0;
    run(2 * FLEN + 10);
    stop = 1'b1; tick(); stop = 1'b0;
    run(100);
    start = 1'b1; tick(); start = 1'b0;
    run(FLEN);
    #1;
    chk("A_frame_syncs", n_fs - b_fs, 3);
    chk("A_done_pulses", n_done - b_done, 1);
    chk("A_ch0_high_cycles", n_s[0] - b_s0, 60);
    chk("A_ch1_high_cycles", n_s[1] - b_s1, 18);
    chk("A_ch3_high_cycles", n_s[3] - b_s3, 288);
    chk("A_ch4_high_cycles", n_s[4] - b_s4, 3);
    chk("A_busy_after_drain", int'(busy), 0);

    // Scenario B: mid-frame rewrite, write on wrap cycle, reset mid-frame
    cfg_write(3, 2040, 20);
    start = 1'b1; tick(); start = 1'b0;
    run(2000);
    cfg_write(0, 500, 20);
    run(LAST - 2001);
    cfg_write(2, 300, 10);
    run(2047);
    #1;
    b_done = n_done;
    chk("B_ch3_high_before_reset", int'(strobe[3]), 1);
    rst = 1'b1; tick(); rst = 1'b0;
    run(5);
    #1;
    chk("B_no_done_on_reset", n_done - b_done, 0);

    // Randomised traffic
    for (int k = 0; k < 6000; k++) begin
      bit acc;
      if (!cfg_valid && $urandom_range(0, 39) == 0) begin
        cfg_valid = 1'b1;
        cfg_ch    = 3'($urandom_range(0, 7));
        cfg_phase = FBITS'($urandom);
        cfg_width = WBITS'($urandom);
      end
      start = (k == 0) || ($urandom_range(0, 999) == 0);
      stop  = ($urandom_range(0, 2999) == 0);
      rst   = ($urandom_range(0, 4999) == 0);
      acc   = cfg_valid && cfg_ready;
      tick();
      if (acc) cfg_valid = 1'b0;
    end
    start = 1'b0; stop = 1'b0; rst = 1'b0; cfg_valid = 1'b0;

`ifdef LED_STROBE_BURST_EN
    // Burst runs: three frames, then continuous
    rst = 1'b1; tick(); rst = 1'b0;
    cfg_write(0, 100, 20);
    burst_len = 16'd3;
    #1;
    b_fs = n_fs; b_done = n_done;
    start = 1'b1; tick(); start = 1'b0;
    run(3 * FLEN + 50);
    #1;
    chk("burst3_frame_syncs", n_fs - b_fs, 3);
    chk("burst3_done_pulses", n_done - b_done, 1);
    burst_len = 16'd0;
    b_fs = n_fs; b_done = n_done;
    start = 1'b1; tick(); start = 1'b0;
    run(10 * FLEN + 5);
    #1;
    chk("burst0_frame_syncs", n_fs - b_fs, 11);
    chk("burst0_still_busy", int'(busy), 1);
    chk("burst0_no_done", n_done - b_done, 0);
    rst = 1'b1; tick(); rst = 1'b0;
`endif

    run(2);
    repeat (2) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/led_strobe_gen.md
LED_STROBE_GEN -- requirements
Module: led_strobe_gen

Interface
REQ-001 Parameter NCH, 5, number of emitter strobe channels.
REQ-002 Parameter FBITS, 12, frame counter width; frame length 2^FBITS clocks.
REQ-003 Parameter WBITS, 8, pulse-width field width.
REQ-004 Reset rst, synchronous, active-high; clock clk.
REQ-005 clk  in  1  system clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 cfg_valid  in  1  configuration write request.
REQ-008 cfg_ready  out  1  configuration write accepted when high with cfg_valid.
REQ-009 cfg_ch  in  3  target channel index.
REQ-010 cfg_phase  in  FBITS  strobe rising-edge offset within frame.
REQ-011 cfg_width  in  WBITS  strobe high time in clocks.
REQ-012 start  in  1  begin strobing.
REQ-013 stop  in  1  request stop at end of current frame.
REQ-014 burst_len  in  16  frames per run, 0 = continuous (present only with BURST_EN).
REQ-015 strobe  out  NCH  emitter drive, one bit per channel.
REQ-016 frame_sync  out  1  one-cycle pulse marking frame start.
REQ-017 busy  out  1  high in RUN or DRAIN.
REQ-018 done  out  1  one-cycle pulse on return to IDLE.

Function
REQ-019 States: IDLE, RUN, DRAIN; IDLE->RUN on start; RUN->DRAIN on stop; DRAIN->IDLE when counter = 2^FBITS-1.
REQ-020 start outside IDLE and stop in IDLE are ignored; start and stop together in IDLE keeps IDLE.
REQ-021 Frame counter clears to 0 on IDLE->RUN, increments every cycle in RUN/DRAIN, wraps 2^FBITS-1 -> 0.
REQ-022 Write handshake: transfer when cfg_valid and cfg_ready; writes pending phase/width of cfg_ch; cfg_ch >= NCH is accepted and discarded.
REQ-023 cfg_ready is low only in the cycle counter = 2^FBITS-1 in RUN/DRAIN, otherwise high.
REQ-024 Active phase/width load from pending on IDLE->RUN and on every counter wrap; never mid-frame.
REQ-025 Channel i is active when phase <= counter < phase+width, sum computed FBITS+1 bits; no wrap into next frame; width 0 never asserts.
REQ-026 strobe and frame_sync are registered: value in cycle k+1 reflects counter in cycle k; frame_sync high the cycle after counter = 0.
REQ-027 strobe is forced 0 in IDLE (one cycle after leaving DRAIN).
REQ-028 done pulses in the first IDLE cycle after DRAIN.
REQ-029 A stop in DRAIN has no further effect.

Reset
REQ-030 rst returns state to IDLE, counter to 0, all pending and active phase/width to 0.
REQ-031 Output reset values: strobe 0, frame_sync 0, busy 0, done 0, cfg_ready 1.
REQ-032 rst mid-frame aborts immediately without done pulse.

Configuration
REQ-033 Macro LED_STROBE_BURST_EN present: burst_len port exists; frames counted from 1 at each wrap; when count equals burst_len (non-zero) in RUN, transition to DRAIN as if stop, last frame completes.
REQ-034 Macro absent: no burst_len port, no frame counter of runs; runs only end via stop.

Structure
REQ-035 Package led_strobe_pkg holds state enum, FBITS/WBITS/NCH defaults and FRAME_LAST constant.
REQ-036 Sub-module strobe_channel holds pending/active regs and window compare for one channel; instantiated NCH times.

Verification
REQ-037 Ch0 phase 100 width 20, start -> strobe[0] high for counter 100..119 each frame (cycles 101..120 after start), frame_sync every 4096 cycles.
REQ-038 Ch1 phase 4090 width 20 -> strobe[1] high 6 cycles only, no spill past wrap.
REQ-039 Write ch0 phase 500 at counter 2000 -> current frame unchanged, new phase from next frame; write at counter 4095 held until cfg_ready returns.
REQ-040 stop at counter 10 -> busy until frame end, done pulse once, strobe 0 after; start during DRAIN ignored.
REQ-041 With LED_STROBE_BURST_EN, burst_len 3 -> exactly 3 frame_sync pulses then done; burst_len 0 runs 10+ frames.
REQ-042 rst asserted at counter 2048 with strobes high -> all outputs reset next cycle, no done pulse.
